// File: rtl/decrypt_engine.sv
// decrypt_engine: iterative AES-128 decryptor, one round per cycle, on-chip key schedule.
// Build option DECRYPT_KEY_ZEROIZE_EN: halt also wipes the round keys, round state and out.

package decrypt_engine_pkg;
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
endpackage

module add_round_key (
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  assign result = data ^ round_key;
endmodule

// Blocks are column-major with byte 0 in bits [127:120]; row r rotates right by r.
module inv_shift_rows (
  input  logic [127:0] data,
  output logic [127:0] result
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign result[127-8*(4*c+r) -: 8] = data[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [127:0] data,
  output logic [127:0] result
);
  import decrypt_engine_pkg::*;
  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign result[127-8*k -: 8] = inv_sbox(data[127-8*k -: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [127:0] data,
  output logic [127:0] result
);
  import decrypt_engine_pkg::*;
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = data[127-32*c -: 32];
    assign result[127-32*c -: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  end
endmodule

module key_expansion_stage (
  input  logic [127:0] prev_key,
  input  logic [3:0]   round_idx,
  output logic [127:0] next_key
);
  import decrypt_engine_pkg::*;
  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
  logic [7:0]  rcon;

  always_comb begin
    case (round_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = prev_key;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};
endmodule

// Handshake: a block transfers on the rising edge where in_valid && in_ready; in_ready is
// high only in READY. out_valid is a one-cycle pulse; out holds its value between pulses.
module decrypt_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set_key,
  input  logic [127:0] key,
  input  logic         halt,
  input  logic         in_valid,
  input  logic [127:0] state,
  output logic         in_ready,
  output logic [127:0] out,
  output logic         out_valid,
  output logic [1:0]   dbg_state
);
  typedef enum logic [1:0] {INIT = 2'd0, KEY_GEN = 2'd1, READY = 2'd2, ROUND = 2'd3} fsm_t;

  fsm_t         fsm;
  logic [127:0] rk [0:10];
  logic [127:0] s;
  logic [3:0]   rc;
  logic [3:0]   gen_idx;
  logic [127:0] gen_prev, gen_next, round_key, whitened, isr, isb, ark, imc;

  always_comb begin
    gen_prev = rk[0];
    for (int i = 1; i <= 10; i++)
      if (gen_idx == i[3:0]) gen_prev = rk[i-1];
  end

  always_comb begin
    round_key = rk[0];
    for (int i = 0; i <= 10; i++)
      if (rc == i[3:0]) round_key = rk[i];
  end

  key_expansion_stage u_key_exp (.prev_key(gen_prev), .round_idx(gen_idx), .next_key(gen_next));
  add_round_key       u_whiten  (.data(state), .round_key(rk[10]), .result(whitened));
  inv_shift_rows      u_isr     (.data(s), .result(isr));
  inv_sub_bytes       u_isb     (.data(isr), .result(isb));
  add_round_key       u_ark     (.data(isb), .round_key(round_key), .result(ark));
  inv_mix_columns     u_imc     (.data(ark), .result(imc));

  assign dbg_state = fsm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= INIT;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
      s         <= '0;
      rc        <= '0;
      gen_idx   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (halt) begin
        fsm      <= INIT;
        in_ready <= 1'b0;
`ifdef DECRYPT_KEY_ZEROIZE_EN
        for (int i = 0; i <= 10; i++) rk[i] <= '0;
        s   <= '0;
        out <= '0;
`endif
      end else begin
        case (fsm)
          INIT: begin
            if (set_key) begin
              rk[0]   <= key;
              gen_idx <= 4'd1;
              fsm     <= KEY_GEN;
            end
          end
          KEY_GEN: begin
            for (int i = 1; i <= 10; i++)
              if (gen_idx == i[3:0]) rk[i] <= gen_next;
            if (gen_idx == 4'd10) begin
              fsm      <= READY;
              in_ready <= 1'b1;
            end else begin
              gen_idx <= gen_idx + 4'd1;
            end
          end
          READY: begin
            if (in_valid) begin
              s        <= whitened;
              rc       <= 4'd9;
              fsm      <= ROUND;
              in_ready <= 1'b0;
            end
          end
          ROUND: begin
            // The final round skips InvMixColumns and writes straight to out.
            if (rc == 4'd0) begin
              out       <= ark;
              out_valid <= 1'b1;
              fsm       <= READY;
              in_ready  <= 1'b1;
            end else begin
              s  <= imc;
              rc <= rc - 4'd1;
            end
          end
          default: fsm <= INIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decrypt_engine.sv
// Bench for decrypt_engine: FIPS-197 vectors plus random blocks whose ciphertext comes from
// a forward AES-128 model, checked by a scoreboard monitor; honours DECRYPT_KEY_ZEROIZE_EN.
module tb_decrypt_engine;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [1:0]   ST_INIT  = 2'd0;
  localparam logic [1:0]   ST_READY = 2'd2;

  logic         clk = 1'b0;
  logic         rst_n, set_key, halt, in_valid;
  logic [127:0] key, state, out;
  logic         in_ready, out_valid;
  logic [1:0]   dbg_state;

  int           checks = 0;
  int           fails = 0;
  int           cyc = 0;
  int           ov_count = 0;
  int           last_acc_cyc = 0;
  logic         prev_ov = 1'b0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic [127:0] mon_exp;
  int           mon_acc;
  logic [7:0]   sbox_t [256];

  decrypt_engine dut (
    .clk(clk), .rst_n(rst_n), .set_key(set_key), .key(key), .halt(halt),
    .in_valid(in_valid), .state(state), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box built by walking generator 3 and its inverse, then forward AES-128.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) begin
      t = w[j/4];
      st[j] = pt[127-8*j -: 8] ^ t[31-8*(j%4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) st[j] = sbox_t[st[j]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) tmp[4*c+rr] = st[4*((c+rr)%4)+rr];
      st = tmp;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          st[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) begin
        t = w[4*r + j/4];
        st[j] = st[j] ^ t[31-8*(j%4) -: 8];
      end
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
    return res;
  endfunction

  // driver tasks
  task automatic load_key(input logic [127:0] k);
    int n;
    @(negedge clk);
    key = k;
    set_key = 1'b1;
    @(negedge clk);
    set_key = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("key_gen_cycles", n, 10);
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      in_valid = ($urandom_range(0, 1) == 1);
      state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready %b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    state = ct;
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    if (push) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
    state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_halt();
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d blocks still pending, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      ov_count++;
      check("out_valid_width", prev_ov, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: out_valid with out %h, required no pulse", out);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        check("plaintext", out, mon_exp);
        check("latency", cyc - mon_acc, 10);
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    int ov0, prev_acc;
    logic [127:0] rkey, pt;
    build_sbox();
    rst_n = 1'b0; set_key = 1'b0; halt = 1'b0; in_valid = 1'b0; key = '0; state = '0;
    repeat (3) @(negedge clk);
    check("reset_out", out, 128'h0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_state", dbg_state, ST_INIT);
    rst_n = 1'b1;

    // FIPS-197 C.1, then halt after completion
    load_key(C1_KEY);
    send_block(C1_CT, C1_PT, 1'b1);
    wait_drain();
    do_halt();
    check("halt_state", dbg_state, ST_INIT);
    check("halt_in_ready", in_ready, 1'b0);
`ifdef DECRYPT_KEY_ZEROIZE_EN
    check("out_after_halt", out, 128'h0);
`else
    check("out_after_halt", out, C1_PT);
`endif

    // FIPS-197 App. B, then back-to-back stream under the same key
    load_key(B_KEY);
    send_block(B_CT, B_PT, 1'b1);
    for (int i = 0; i < 6; i++) begin
      prev_acc = last_acc_cyc;
      pt = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) send_block(B_CT, B_PT, 1'b1);
      else send_block(aes_encrypt(B_KEY, pt), pt, 1'b1);
      check("b2b_spacing", last_acc_cyc - prev_acc, 11);
    end
    wait_drain();

    // halt mid-round drops the block; reload with key B
    do_halt();
    load_key(C1_KEY);
    send_block(C1_CT, C1_PT, 1'b0);
    repeat (4) @(negedge clk);
    halt = 1'b1;
    ov0 = ov_count;
    @(negedge clk);
    halt = 1'b0;
    check("midround_halt_state", dbg_state, ST_INIT);
    check("midround_halt_in_ready", in_ready, 1'b0);
    repeat (15) @(negedge clk);
    check("midround_halt_no_out", ov_count - ov0, 0);
    load_key(B_KEY);
    send_block(B_CT, B_PT, 1'b1);
    wait_drain();

    // reset mid-round, then set_key in READY must be ignored
    send_block(B_CT, B_PT, 1'b0);
    repeat (4) @(negedge clk);
    ov0 = ov_count;
    rst_n = 1'b0;
    #1;
    check("midround_rst_out", out, 128'h0);
    check("midround_rst_out_valid", out_valid, 1'b0);
    check("midround_rst_in_ready", in_ready, 1'b0);
    check("midround_rst_state", dbg_state, ST_INIT);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midround_rst_no_out", ov_count - ov0, 0);
    load_key(C1_KEY);
    @(negedge clk);
    key = B_KEY;
    set_key = 1'b1;
    @(negedge clk);
    set_key = 1'b0;
    @(negedge clk);
    check("ignored_set_key_state", dbg_state, ST_READY);
    check("ignored_set_key_in_ready", in_ready, 1'b1);
    send_block(C1_CT, C1_PT, 1'b1);
    wait_drain();

    // random keys and plaintexts with random idle gaps
    for (int k = 0; k < 3; k++) begin
      do_halt();
      rkey = {$urandom, $urandom, $urandom, $urandom};
      load_key(rkey);
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(aes_encrypt(rkey, pt), pt, 1'b1);
      end
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/decrypt_engine.md
DECRYPT_ENGINE -- requirements
Module: decrypt_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 set_key  input  1  loads key; honoured only in INIT.
REQ-005 key  input  128  AES-128 cipher key, sampled with set_key.
REQ-006 halt  input  1  abort; returns FSM to INIT from any state.
REQ-007 in_valid  input  1  ciphertext present on state.
REQ-008 state  input  128  ciphertext block.
REQ-009 in_ready  output  1  high only in READY; block accepted on edge with in_valid&&in_ready.
REQ-010 out  output  128  plaintext; holds last result between pulses.
REQ-011 out_valid  output  1  one-cycle pulse marking new out.

Function
REQ-012 FSM states SHALL be INIT, KEY_GEN, READY, ROUND.
REQ-013 INIT: set_key=1 SHALL latch key into rk[0], set gen index to 1, and go to KEY_GEN; all other inputs except halt are ignored.
REQ-014 KEY_GEN SHALL produce one round key per cycle, rk[i] = key_expansion_stage(rk[i-1], round_idx=i) for i=1..10, for exactly 10 cycles, then go to READY.
REQ-015 READY SHALL assert in_ready; on accept it SHALL load s <= state XOR rk[10], set rc=9, and go to ROUND.
REQ-016 ROUND with rc in 9..1: s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) XOR rk[rc]); rc <= rc-1.
REQ-017 ROUND with rc=0: out <= InvSubBytes(InvShiftRows(s)) XOR rk[0]; out_valid=1 for the next cycle only; FSM to READY.
REQ-018 Latency: out_valid SHALL rise after the 10th rising edge following the accept edge; throughput is one block per 11 cycles.
REQ-019 in_valid outside READY SHALL be ignored, with no buffering.
REQ-020 A new block MAY be accepted in the cycle that out_valid is high.
REQ-021 set_key outside INIT SHALL be ignored; the round keys are unchanged.
REQ-022 halt SHALL take priority over every other input in every state; next state is INIT; an in-flight block is dropped with no out_valid.
REQ-023 After halt, a new set_key and the full 10-cycle KEY_GEN SHALL be required before in_ready rises again.
REQ-024 The round datapath SHALL reuse the codebase addRoundKey and key_expansion_stage, plus invSubBytes, invShiftRows and invMixColumns submodules; the design has one round instance, iterated.

Reset
REQ-025 rst_n low SHALL asynchronously force: FSM=INIT, rk[0..10]=0, s=0, rc=0, out=0, out_valid=0, in_ready=0.
REQ-026 Reset during KEY_GEN or ROUND SHALL discard all progress, and no out_valid SHALL follow.

Configuration
REQ-027 Macro DECRYPT_KEY_ZEROIZE_EN defined: halt SHALL clear rk[0..10], s and out to zero on the same edge it enters INIT.
REQ-028 DECRYPT_KEY_ZEROIZE_EN undefined: halt SHALL retain rk, s and out values, which are unusable until the next set_key.

Verification
REQ-029 FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, set_key, wait for in_ready, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out=00112233445566778899aabbccddeeff, out_valid on 10th edge after accept, one cycle wide.
REQ-030 FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734; in_ready rises exactly 10 cycles after set_key.
REQ-031 Back-to-back: hold in_valid=1 with C.1 then B ciphertexts -> second accept occurs in the out_valid cycle; both plaintexts are correct, 11 cycles apart; in_valid pulses during ROUND have no effect.
REQ-032 halt on round 5 of C.1 -> no out_valid; in_ready=0; FSM in INIT; a new set_key with the B key and B ciphertext gives the B plaintext.
REQ-033 rst_n low for one cycle mid-ROUND -> all outputs 0 immediately; no out_valid; set_key in READY ignored (a C.1 key later replaced by a B key is not applied).
REQ-034 With DECRYPT_KEY_ZEROIZE_EN, halt after C.1 completes -> out=0 and round-key store all zero on the next cycle; without the macro, out keeps 00112233445566778899aabbccddeeff.
